spi_xfer_seq: RTL and testbench

//  Command-driven transfer sequencer and register-bus master for the SPI chip's master mode.

---
 rtl/spi_xfer_seq_if.sv | 27 ++
 rtl/spi_xfer_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_seq_if.sv
// Register-port bundle between the transfer sequencer (master) and the SPI top (slave).
//   stb_o  : access strobe, held until ack_i
//   addr_o : 00 ctrl, 01 status, 10 data, 11 ssn
//   we_o   : 1 = write, 0 = read
//   data_o : write data
//   data_i : read data, valid with ack_i
//   ack_i  : access termination
//   int_i  : byte-complete interrupt, held by the core until cleared
interface spi_xfer_seq_if;
  logic       stb_o;
  logic [1:0] addr_o;
  logic       we_o;
  logic [7:0] data_o;
  logic [7:0] data_i;
  logic       ack_i;
  logic       int_i;

  modport master (
    output stb_o, addr_o, we_o, data_o,
    input  data_i, ack_i, int_i
  );

  modport slave (
    input  stb_o, addr_o, we_o, data_o,
    output data_i, ack_i, int_i
  );
endinterface

// File: rtl/spi_xfer_seq.sv
// Command-driven transfer sequencer and register-bus master for SPI master mode.
// A command {ssn, len} is turned into: config write, slave select, then per byte
// data write / wait for interrupt / data read / flag clear, and finally deselect.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   cmd_valid_i/ready_o   : command handshake, ready only when idle
//   cmd_ssn_i, cmd_len_i  : slave index 0..7, byte count (0 = no-op)
//   tx_valid_i/ready_o    : tx byte handshake, ready only while waiting for a byte
//   tx_data_i             : tx byte
//   rx_valid_o, rx_data_o : one-cycle pulse with the byte read back
//   busy_o                : command in progress
//   done_o, err_o         : end-of-command pulse; err_o flags a timeout abort
//   bus                   : register port towards the SPI top
module spi_xfer_seq #(
  parameter logic [7:0]  ConCfg  = 8'hA0,
  parameter int unsigned Timeout = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_ssn_i,
  input  logic [7:0] cmd_len_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  spi_xfer_seq_if.master bus
);

  localparam logic [1:0] AddrCtrl = 2'b00;
  localparam logic [1:0] AddrSts  = 2'b01;
  localparam logic [1:0] AddrData = 2'b10;
  localparam logic [1:0] AddrSsn  = 2'b11;
  localparam logic [9:0] TmoLast  = 10'(Timeout - 1);

  typedef enum logic [3:0] {
    StIdle, StCfg, StSel, StTxw, StWr, StWait, StRd, StSts, StDesel
  } state_e;

  state_e     state_q, state_d;
  logic       stb_q, stb_d;
  logic [1:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic [2:0] ssn_q, ssn_d;
  logic [8:0] rem_q, rem_d;
  logic [7:0] tx_q, tx_d;
  logic [9:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;

  // Access wanted by the current bus state and the state that follows its ack.
  logic       acc_bus;
  logic [1:0] acc_addr;
  logic       acc_we;
  logic [7:0] acc_data;
  state_e     acc_next;

  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ssn_d      = ssn_q;
    rem_d      = rem_q;
    tx_d       = tx_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    acc_bus    = 1'b0;
    acc_addr   = AddrCtrl;
    acc_we     = 1'b1;
    acc_data   = 8'h00;
    acc_next   = state_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          ssn_d = cmd_ssn_i;
          rem_d = {1'b0, cmd_len_i};
          err_d = 1'b0;
          if (cmd_len_i == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StCfg;
          end
        end
      end
      StCfg: begin
        acc_bus  = 1'b1;
        acc_addr = AddrCtrl;
        acc_data = ConCfg;
        acc_next = StSel;
      end
      StSel: begin
        acc_bus  = 1'b1;
        acc_addr = AddrSsn;
        acc_data = ~(8'h01 << ssn_q);
        acc_next = StTxw;
      end
      StTxw: begin
        if (tx_valid_i) begin
          tx_d    = tx_data_i;
          state_d = StWr;
        end
      end
      StWr: begin
        acc_bus  = 1'b1;
        acc_addr = AddrData;
        acc_data = tx_q;
        acc_next = StWait;
      end
      StWait: begin
        if (bus.int_i) begin
          state_d = StRd;
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDesel;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      StRd: begin
        acc_bus  = 1'b1;
        acc_addr = AddrData;
        acc_we   = 1'b0;
        acc_next = StSts;
      end
      StSts: begin
        acc_bus  = 1'b1;
        acc_addr = AddrSts;
        acc_data = 8'h80;
        acc_next = (rem_q == 9'd1) ? StDesel : StTxw;
      end
      StDesel: begin
        acc_bus  = 1'b1;
        acc_addr = AddrSsn;
        acc_data = 8'hFF;
        acc_next = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Each bus state issues its access on entry and leaves on ack; stb is low for the
    // cycle after every ack, so back-to-back accesses get a one-cycle gap.
    if (acc_bus) begin
      if (!stb_q) begin
        stb_d   = 1'b1;
        addr_d  = acc_addr;
        we_d    = acc_we;
        wdata_d = acc_data;
      end else if (bus.ack_i) begin
        stb_d   = 1'b0;
        state_d = acc_next;
        if (state_q == StWr) tmo_d = '0;
        if (state_q == StRd) begin
          rx_data_d  = bus.data_i;
          rx_valid_d = 1'b1;
        end
        if (state_q == StSts) rem_d = rem_q - 9'd1;
        if (state_q == StDesel) done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      stb_q      <= 1'b0;
      addr_q     <= 2'b00;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      ssn_q      <= 3'd0;
      rem_q      <= 9'd0;
      tx_q       <= 8'h00;
      tmo_q      <= 10'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ssn_q      <= ssn_d;
      rem_q      <= rem_d;
      tx_q       <= tx_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign tx_ready_o  = (state_q == StTxw);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign bus.stb_o   = stb_q;
  assign bus.addr_o  = addr_q;
  assign bus.we_o    = we_q;
  assign bus.data_o  = wdata_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
module tb_spi_xfer_seq;
  localparam logic [7:0] ConCfg = 8'hA0;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [2:0] cmd_ssn_i;
  logic [7:0] cmd_len_i;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  spi_xfer_seq_if bus_if ();

  spi_xfer_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_ssn_i   (cmd_ssn_i),
    .cmd_len_i   (cmd_len_i),
    .tx_valid_i  (tx_valid_i),
    .tx_data_i   (tx_data_i),
    .tx_ready_o  (tx_ready_o),
    .rx_valid_o  (rx_valid_o),
    .rx_data_o   (rx_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .bus         (bus_if)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI top model (register slave) ----------------
  int         ack_dly_max = 2;
  int         ack_dly_fix = -1;
  bit         int_en      = 1'b1;
  int         int_dly_max = 15;
  int         int_dly_fix = -1;
  bit         rd_fix_en   = 1'b0;
  logic [7:0] rd_fix      = 8'h00;
  logic [10:0] bus_log[$];
  logic [7:0]  rd_log[$];
  int         cyc = 0;
  int         wr_ack_cyc = 0;
  int         stb_rise_cyc = 0;
  logic       stb_prev = 1'b0;
  logic [10:0] held;
  int         ack_cnt = -1;
  int         int_cnt = -1;

  initial begin
    bus_if.ack_i  = 1'b0;
    bus_if.int_i  = 1'b0;
    bus_if.data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (bus_if.stb_o && !stb_prev) begin
        stb_rise_cyc = cyc;
        held = {bus_if.we_o, bus_if.addr_o, bus_if.data_o};
      end else if (bus_if.stb_o && stb_prev) begin
        chk("bus_hold", {21'd0, bus_if.we_o, bus_if.addr_o, bus_if.data_o}, {21'd0, held});
      end
      stb_prev = bus_if.stb_o;
      if (rst_i) begin
        bus_if.ack_i = 1'b0;
        bus_if.int_i = 1'b0;
        ack_cnt = -1;
        int_cnt = -1;
      end else begin
        if (bus_if.ack_i) begin
          bus_if.ack_i = 1'b0;
        end else if (bus_if.stb_o) begin
          if (ack_cnt < 0) ack_cnt = (ack_dly_fix >= 0) ? ack_dly_fix : $urandom_range(ack_dly_max, 0);
          if (ack_cnt == 0) begin
            bus_if.ack_i = 1'b1;
            ack_cnt = -1;
            if (!bus_if.we_o) begin
              bus_if.data_i = rd_fix_en ? rd_fix : 8'($urandom);
              rd_log.push_back(bus_if.data_i);
              bus_log.push_back({1'b0, bus_if.addr_o, 8'h00});
            end else begin
              bus_log.push_back({1'b1, bus_if.addr_o, bus_if.data_o});
              if (bus_if.addr_o == 2'b10) begin
                wr_ack_cyc = cyc;
                if (int_en) int_cnt = (int_dly_fix >= 0) ? int_dly_fix : $urandom_range(int_dly_max, 0);
              end
              if (bus_if.addr_o == 2'b01 && bus_if.data_o == 8'h80) bus_if.int_i = 1'b0;
            end
          end else begin
            ack_cnt--;
          end
        end
        if (int_cnt == 0) begin
          bus_if.int_i = 1'b1;
          int_cnt = -1;
        end else if (int_cnt > 0) begin
          int_cnt--;
        end
      end
    end
  end

  // ---------------- tx byte source ----------------
  logic [7:0] tx_q[$];
  int         tx_idx = 0;
  int         stall_at = -1;
  int         stall_len = 0;
  int         stall_cnt = 0;
  bit         hs_pend = 1'b0;

  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (hs_pend) begin
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        tx_idx++;
        hs_pend = 1'b0;
        tx_valid_i = 1'b0;
      end
      if (rst_i || tx_q.size() == 0) begin
        tx_valid_i = 1'b0;
      end else if (tx_idx == stall_at && stall_cnt < stall_len) begin
        tx_valid_i = 1'b0;
        if (tx_ready_o) begin
          stall_cnt++;
          chk("stall_no_bus", {31'd0, bus_if.stb_o}, 32'd0);
        end
      end else if (tx_valid_i || $urandom_range(3, 0) != 0) begin
        tx_valid_i = 1'b1;
        tx_data_i  = tx_q[0];
      end
      hs_pend = tx_valid_i && tx_ready_o && !rst_i;
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] rx_got[$];
  int         done_cnt = 0;
  logic       done_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (rx_valid_o) rx_got.push_back(rx_data_o);
      if (done_o) begin
        done_cnt++;
        done_err = err_o;
      end
    end
  end

  // ---------------- command runner with reference model ----------------
  logic [7:0] tx_plan[$];

  task automatic run_cmd(input logic [2:0] ssn, input logic [7:0] len, input bit tmo,
                         input int hold);
    logic [10:0] exp_bus[$];
    logic [7:0]  txb[$];
    int          waited;
    int          nbytes;
    txb = tx_plan;
    tx_plan.delete();
    while (txb.size() < int'(len)) txb.push_back(8'($urandom));
    bus_log.delete();
    rd_log.delete();
    rx_got.delete();
    done_cnt  = 0;
    done_err  = 1'b0;
    tx_idx    = 0;
    stall_cnt = 0;
    tx_q      = txb;
    // Expected register traffic derived from the command alone.
    nbytes = tmo ? 1 : int'(len);
    if (len != 8'd0) begin
      exp_bus.push_back({1'b1, 2'b00, ConCfg});
      exp_bus.push_back({1'b1, 2'b11, ~(8'h01 << ssn)});
      for (int i = 0; i < nbytes; i++) begin
        exp_bus.push_back({1'b1, 2'b10, txb[i]});
        if (!tmo) begin
          exp_bus.push_back({1'b0, 2'b10, 8'h00});
          exp_bus.push_back({1'b1, 2'b01, 8'h80});
        end
      end
      exp_bus.push_back({1'b1, 2'b11, 8'hFF});
    end

    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_ssn_i   = ssn;
    cmd_len_i   = len;
    chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge clk_i);
    chk("err_clr_on_accept", {31'd0, err_o}, 32'd0);
    if (len == 8'd0) chk("len0_done_next", {31'd0, done_o}, 32'd1);
    else chk("busy_after_accept", {31'd0, busy_o}, 32'd1);
    if (hold > 0) begin
      cmd_ssn_i = ~ssn;
      cmd_len_i = len + 8'd3;
      for (int i = 0; i < hold; i++) begin
        chk("ready_low_busy", {31'd0, cmd_ready_o}, 32'd0);
        @(negedge clk_i);
      end
    end
    cmd_valid_i = 1'b0;

    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(negedge clk_i);
      waited++;
    end
    repeat (3) @(negedge clk_i);
    chk("done_once", done_cnt, 1);
    chk("done_err", {31'd0, done_err}, {31'd0, tmo});
    chk("idle_after", {31'd0, busy_o}, 32'd0);
    chk("stb_idle", {31'd0, bus_if.stb_o}, 32'd0);
    chk("tx_used", tx_idx, nbytes);
    chk("bus_count", bus_log.size(), exp_bus.size());
    for (int i = 0; i < exp_bus.size(); i++)
      chk($sformatf("bus_seq[%0d]", i), (i < bus_log.size()) ? {21'd0, bus_log[i]} : 'x,
          {21'd0, exp_bus[i]});
    chk("rx_count", rx_got.size(), tmo ? 0 : nbytes);
    for (int i = 0; i < rd_log.size(); i++)
      chk($sformatf("rx_data[%0d]", i), (i < rx_got.size()) ? {24'd0, rx_got[i]} : 'x,
          {24'd0, rd_log[i]});
    tx_q.delete();
  endtask

  initial begin
    int waited;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_ssn_i   = 3'd0;
    cmd_len_i   = 8'd0;

    // Reset values.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
    chk("rst_stb", {31'd0, bus_if.stb_o}, 32'd0);
    chk("rst_addr", {30'd0, bus_if.addr_o}, 32'd0);
    chk("rst_we", {31'd0, bus_if.we_o}, 32'd0);
    chk("rst_wdata", {24'd0, bus_if.data_o}, 32'd0);
    rst_i = 1'b0;

    // Single byte, fixed data, slow interrupt.
    ack_dly_fix = 1;
    int_dly_fix = 20;
    rd_fix_en   = 1'b1;
    rd_fix      = 8'hC3;
    tx_plan.push_back(8'h5A);
    run_cmd(3'd3, 8'd1, 1'b0, 0);
    chk("rx_c3", (rx_got.size() > 0) ? {24'd0, rx_got[0]} : 'x, 32'h0000_00C3);
    ack_dly_fix = -1;
    int_dly_fix = -1;
    rd_fix_en   = 1'b0;

    // Four bytes with a stall in front of the third.
    stall_at  = 2;
    stall_len = 5;
    run_cmd(3'd6, 8'd4, 1'b0, 0);
    chk("stall_cycles", stall_cnt, 5);
    stall_at = -1;

    // Interrupt never arrives: timeout abort.
    int_en = 1'b0;
    run_cmd(3'd5, 8'd1, 1'b1, 0);
    waited = stb_rise_cyc - wr_ack_cyc;
    chk("tmo_window", (waited >= 1023 && waited <= 1026) ? 32'd1 : 32'd0, 32'd1);
    chk("err_held", {31'd0, err_o}, 32'd1);
    int_en = 1'b1;
    run_cmd(3'd0, 8'd2, 1'b0, 0);

    // Zero-length command, then a command offered again while busy.
    run_cmd(3'd2, 8'd0, 1'b0, 0);
    int_dly_fix = 12;
    run_cmd(3'd1, 8'd1, 1'b0, 5);
    int_dly_fix = -1;

    // Randomised commands.
    ack_dly_max = 3;
    for (int n = 0; n < 6; n++)
      run_cmd(3'($urandom_range(7, 0)), 8'($urandom_range(6, 1)), 1'b0, 0);

    // Reset in the middle of a data write.
    ack_dly_fix = 8;
    done_cnt = 0;
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_idx = 0;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_ssn_i   = 3'd1;
    cmd_len_i   = 8'd2;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    waited = 0;
    while (!(bus_if.stb_o && bus_if.we_o && bus_if.addr_o == 2'b10) && waited < 200) begin
      @(negedge clk_i);
      waited++;
    end
    chk("wr_reached", (waited < 200) ? 32'd1 : 32'd0, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_stb", {31'd0, bus_if.stb_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    tx_q.delete();
    ack_dly_fix = -1;
    repeat (5) @(negedge clk_i);
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_stb_low", {31'd0, bus_if.stb_o}, 32'd0);

    // Recovery after the abort.
    run_cmd(3'd4, 8'd3, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
